// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch path.
//   fetch_state_e : fetch FSM states
//   RESET_PC_DEF  : default first fetch address after reset
//   PC_INC        : sequential PC increment (one 32-bit instruction word)
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    EXEC     = 2'd2,
    TRAP     = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for a committing instruction.
//   pc_plus4_i   : sequential successor of the current PC
//   br_sel_i     : 1 = take branch/jump target
//   br_target_i  : raw target from the ALU (bit 0 is dropped, JALR style)
//   next_pc_o    : selected next PC
//   misalign_o   : next PC is not 4-byte aligned (bit 1 set)
module pc_next_sel (
  input  logic        br_sel_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  always_comb begin
    next_pc_o  = br_sel_i ? (br_target_i & ~32'h1) : pc_plus4_i;
    // Bit 0 is always clear here, so bit 1 alone decides alignment.
    misalign_o = next_pc_o[1];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch unit with PC, retire counter and
// sticky misaligned-target trap.
//   clk, rst          : clock, asynchronous active-high reset
//   NextPCSrc         : 1 = next PC from BrTarget, 0 = PC+4 (used in EXEC only)
//   BrTarget          : branch/jump target
//   commit            : held instruction retires this cycle (used in EXEC only)
//   imem_req_*        : fetch request handshake, word address = pc
//   imem_rsp_*        : fetch response, accepted only while waiting for it
//   inst_valid, inst  : fetched instruction awaiting commit
//   pc, pc_plus4      : current PC and its sequential successor
//   misaligned        : sticky trap flag; unit stops fetching once set
//   instret           : retired-instruction counter
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] BrTarget,
  input  logic        commit,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned,
  output logic [31:0] instret
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  instret_q, instret_d;
  logic         mis_q, mis_d;

  logic [31:0]  next_pc;
  logic         next_mis;

  assign pc_plus4 = pc_q + PC_INC;

  pc_next_sel u_next_sel (
    .br_sel_i    (NextPCSrc),
    .pc_plus4_i  (pc_plus4),
    .br_target_i (BrTarget),
    .next_pc_o   (next_pc),
    .misalign_o  (next_mis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      instret_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    instret_d      = instret_q;
    mis_d          = mis_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (state_q)
      FETCH: begin
        // Address is pc_q, which cannot change in FETCH, so it stays
        // stable for as long as the request is back-pressured.
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        inst_valid = 1'b1;
        if (commit) begin
          instret_d = instret_q + 32'd1;
          if (next_mis) begin
            // Keep the faulting instruction's PC for the trap handler.
            mis_d   = 1'b1;
            state_d = TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      TRAP: ;
      default: state_d = FETCH;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign inst          = inst_q;
  assign pc            = pc_q;
  assign misaligned    = mis_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance 1: default RESET_PC = 0
  logic        NextPCSrc, commit, req_ready, rsp_valid;
  logic [31:0] BrTarget, rsp_data;
  logic        req_valid, inst_valid, misaligned;
  logic [31:0] req_addr, inst, pc, pc_plus4, instret;

  // Instance 2: RESET_PC = FFFF_FFFC (wrap checks)
  logic        NextPCSrc2, commit2, req_ready2, rsp_valid2;
  logic [31:0] BrTarget2, rsp_data2;
  logic        req_valid2, inst_valid2, misaligned2;
  logic [31:0] req_addr2, inst2, pc2, pc_plus42, instret2;

  int n_assert = 0;
  int n_fail   = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .BrTarget(BrTarget), .commit(commit),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
    .misaligned(misaligned), .instret(instret)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc2), .BrTarget(BrTarget2), .commit(commit2),
    .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .inst_valid(inst_valid2), .inst(inst2), .pc(pc2), .pc_plus4(pc_plus42),
    .misaligned(misaligned2), .instret(instret2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    NextPCSrc = 0; commit = 0; req_ready = 0; rsp_valid = 0; BrTarget = '0; rsp_data = '0;
    NextPCSrc2 = 0; commit2 = 0; req_ready2 = 0; rsp_valid2 = 0; BrTarget2 = '0; rsp_data2 = '0;
    tick(); tick();
    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ivld", {31'b0, inst_valid}, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    chk("rst_pc_2", pc2, 32'hFFFF_FFFC);
    chk("rst_pc4_2", pc_plus42, 32'h0);
    rst = 1'b0;
    tick();
    chk("req_after_rst", {31'b0, req_valid}, 32'h1);
    chk("req_addr0", req_addr, 32'h0);

    // Basic fetch, 2-cycle response, sequential commit
    req_ready = 1; tick(); req_ready = 0;
    chk("wait_noreq", {31'b0, req_valid}, 32'h0);
    tick();
    chk("wait_noivld", {31'b0, inst_valid}, 32'h0);
    rsp_valid = 1; rsp_data = 32'h0050_0093; tick(); rsp_valid = 0;
    chk("exec_ivld", {31'b0, inst_valid}, 32'h1);
    chk("exec_inst", inst, 32'h0050_0093);
    tick(); tick();
    chk("exec_hold_ivld", {31'b0, inst_valid}, 32'h1);
    chk("exec_hold_pc", pc, 32'h0);
    commit = 1; NextPCSrc = 0; tick(); commit = 0;
    chk("seq_pc", pc, 32'h4);
    chk("seq_instret", instret, 32'h1);
    chk("seq_req", {31'b0, req_valid}, 32'h1);
    chk("seq_addr", req_addr, 32'h4);

    // Back-pressure 5 cycles with a spurious response in FETCH
    for (int i = 0; i < 5; i++) begin
      rsp_valid = (i == 2); rsp_data = 32'hDEAD_BEEF;
      tick();
      chk("bp_req", {31'b0, req_valid}, 32'h1);
      chk("bp_addr", req_addr, 32'h4);
      chk("bp_noivld", {31'b0, inst_valid}, 32'h0);
    end
    rsp_valid = 0;
    req_ready = 1; tick(); req_ready = 0;
    chk("bp_one_hs", {31'b0, req_valid}, 32'h0);
    tick();
    chk("bp_still_wait", {31'b0, req_valid | inst_valid}, 32'h0);
    rsp_valid = 1; rsp_data = 32'h0000_0013; tick(); rsp_valid = 0;
    chk("bp_inst", inst, 32'h0000_0013);

    // Jump to 0x10
    commit = 1; NextPCSrc = 1; BrTarget = 32'h10; tick(); commit = 0; NextPCSrc = 0;
    chk("jmp10_pc", pc, 32'h10);
    // commit in FETCH must be ignored
    commit = 1; NextPCSrc = 1; BrTarget = 32'h80; req_ready = 1; tick();
    commit = 0; NextPCSrc = 0; req_ready = 0;
    chk("fetch_commit_ign", pc, 32'h10);
    chk("fetch_commit_ret", instret, 32'h2);
    rsp_valid = 1; rsp_data = 32'h0400_006F; tick(); rsp_valid = 0;
    // Branch target with bit 0 set -> bit 0 cleared
    commit = 1; NextPCSrc = 1; BrTarget = 32'h41; tick(); commit = 0; NextPCSrc = 0;
    chk("br41_pc", pc, 32'h40);
    chk("br41_addr", req_addr, 32'h40);
    chk("br41_instret", instret, 32'h3);

    // Misaligned target -> TRAP
    req_ready = 1; tick(); req_ready = 0;
    rsp_valid = 1; rsp_data = 32'h0220_0067; tick(); rsp_valid = 0;
    commit = 1; NextPCSrc = 1; BrTarget = 32'h22; tick(); NextPCSrc = 0;
    chk("trap_mis", {31'b0, misaligned}, 32'h1);
    chk("trap_pc", pc, 32'h40);
    chk("trap_instret", instret, 32'h4);
    req_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("trap_noreq", {31'b0, req_valid}, 32'h0);
      chk("trap_noivld", {31'b0, inst_valid}, 32'h0);
    end
    chk("trap_commit_ign", instret, 32'h4);
    commit = 0; req_ready = 0;

    // Reset exits TRAP; then reset during WAIT_RSP with a late response
    rst = 1; tick(); rst = 0; tick();
    chk("rst2_mis", {31'b0, misaligned}, 32'h0);
    req_ready = 1; tick(); req_ready = 0;
    chk("abort_in_wait", {31'b0, req_valid}, 32'h0);
    #2 rst = 1; #2 rst = 0;
    rsp_valid = 1; rsp_data = 32'hBAD0_BAD0; tick(); rsp_valid = 0;
    chk("late_pc", pc, 32'h0);
    chk("late_ivld", {31'b0, inst_valid}, 32'h0);
    chk("late_inst", inst, 32'h0);
    chk("late_req", {31'b0, req_valid}, 32'h1);

    // Instance 2: PC wrap and instret wrap
    chk("w_addr", req_addr2, 32'hFFFF_FFFC);
    req_ready2 = 1; tick(); req_ready2 = 0;
    rsp_valid2 = 1; rsp_data2 = 32'h0000_0013; tick(); rsp_valid2 = 0;
    chk("w_ivld", {31'b0, inst_valid2}, 32'h1);
    force dut2.instret_q = 32'hFFFF_FFFF;
    #1 release dut2.instret_q;
    chk("w_preload", instret2, 32'hFFFF_FFFF);
    commit2 = 1; NextPCSrc2 = 0; tick(); commit2 = 0;
    chk("w_pc", pc2, 32'h0);
    chk("w_addr0", req_addr2, 32'h0);
    chk("w_instret", instret2, 32'h0);
    chk("w_mis", {31'b0, misaligned2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port NextPCSrc  input  1  branch-unit decision; 1 = take BrTarget, 0 = PC+4.
REQ-005 SHALL have port BrTarget  input  32  branch/jump target from ALU.
REQ-006 SHALL have port commit  input  1  current instruction retires this cycle.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_req_addr  output  32  fetch word address.
REQ-010 SHALL have port imem_rsp_valid  input  1  fetched word valid.
REQ-011 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-012 SHALL have port inst_valid  output  1  inst holds a fetched instruction awaiting commit.
REQ-013 SHALL have port inst  output  32  held instruction.
REQ-014 SHALL have port pc, pc_plus4  output  32 each  current PC and PC+4.
REQ-015 SHALL have port misaligned  output  1  sticky instruction-address-misaligned trap flag.
REQ-016 SHALL have port instret  output  32  retired-instruction counter.

Function
REQ-017 SHALL implement FSM states FETCH, WAIT_RSP, EXEC, TRAP.
REQ-018 FETCH: imem_req_valid=1, imem_req_addr=pc; on imem_req_valid & imem_req_ready SHALL go to WAIT_RSP.
REQ-019 imem_req_addr SHALL stay stable while imem_req_valid=1 and ready=0.
REQ-020 WAIT_RSP: on imem_rsp_valid SHALL capture imem_rsp_data into inst and go to EXEC; imem_rsp_valid outside WAIT_RSP SHALL be ignored (one outstanding request, response no earlier than cycle after acceptance).
REQ-021 EXEC: inst_valid=1; without commit, inst and pc SHALL hold indefinitely.
REQ-022 EXEC with commit: next = NextPCSrc ? {BrTarget[31:1],1'b0} : pc_plus4; instret SHALL increment by 1.
REQ-023 If next[1]=1, SHALL keep pc unchanged, set misaligned, enter TRAP; else pc<=next, enter FETCH.
REQ-024 TRAP SHALL be absorbing until reset: no requests, inst_valid=0, commit ignored.
REQ-025 commit, NextPCSrc, BrTarget SHALL be ignored outside EXEC.
REQ-026 pc_plus4 SHALL equal pc+4 modulo 2^32 combinationally; pc 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 instret SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-028 Fetch-to-inst_valid latency SHALL be exactly one cycle after the imem_rsp_valid cycle.

Reset
REQ-029 On rst: state=FETCH, pc=RESET_PC, inst=0, instret=0, misaligned=0, inst_valid=0; imem_req_valid reasserts first clock after rst deasserts.
REQ-030 rst mid-transaction (WAIT_RSP or EXEC) SHALL abort; a late response arriving in FETCH SHALL be dropped.

Structure
REQ-031 State enum, RESET_PC default and 32'd4 increment SHALL live in shared package riscv_pkg.
REQ-032 One sub-module natural: pc_next_sel (combinational next-PC mux, bit-0 clear, misalign check).

Verification
REQ-033 Reset, ready=1, 2-cycle response 32'h00500093, commit, NextPCSrc=0 -> pc 0->4, instret=1, second request addr 32'h4.
REQ-034 EXEC at pc=32'h10, commit, NextPCSrc=1, BrTarget=32'h41 -> pc=32'h40, next req addr 32'h40.
REQ-035 commit, NextPCSrc=1, BrTarget=32'h22 -> misaligned=1, pc stays, no further imem_req_valid.
REQ-036 imem_req_ready low 5 cycles -> addr held constant, one handshake only; spurious rsp_valid in FETCH ignored.
REQ-037 rst pulse during WAIT_RSP, then late rsp_valid -> pc=RESET_PC, inst_valid=0, response dropped.
REQ-038 RESET_PC=32'hFFFF_FFFC, one commit, NextPCSrc=0 -> pc=0; preload instret=32'hFFFF_FFFF via force -> wraps 0.
